// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Control FSM for a multicycle RV32I-style datapath. It sequences
//               fetch, decode, execute, memory and write-back steps. It also
//               drives the datapath enables, the mux selects and a one-cycle
//               retire pulse for each completed instruction. An unknown opcode
//               parks the FSM in TRAP until reset.
// Ports       : clk, resetn (asynchronous, active-low)
//               opcode[6:0]   - instruction opcode field
//               mem_ready     - memory completes the pending access this cycle
//               branch_taken  - branch-condition result from the datapath
//               pc_write, ir_write, mem_req, mem_we, reg_write - enables
//               adr_src, alu_src_a, alu_src_b, alu_op, result_src - selects
//               retire, trap  - instruction complete / illegal-opcode flag
//               state[3:0]    - current state encoding, for debug
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl (
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_req,
    output logic       mem_we,
    output logic       reg_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       retire,
    output logic       trap,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LINK     = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    state_t r_state;
    // Clear while in reset and set by the first clk edge after release. It
    // keeps every output quiet until that edge, so the first FETCH (and its
    // mem_req) starts on a clock edge and not on the resetn edge itself.
    logic   r_run;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_FETCH;
            r_run   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_run) begin
                case (r_state)
                    S_FETCH:    if (mem_ready) r_state <= S_DECODE;
                    S_DECODE: begin
                        case (opcode)
                            c_OP_LOAD,
                            c_OP_STORE:  r_state <= S_MEMADR;
                            c_OP_RTYPE:  r_state <= S_EXECR;
                            c_OP_ITYPE:  r_state <= S_EXECI;
                            c_OP_JAL:    r_state <= S_JAL;
                            c_OP_JALR:   r_state <= S_JALR;
                            c_OP_BRANCH: r_state <= S_BRANCH;
                            c_OP_LUI:    r_state <= S_LUI;
                            c_OP_AUIPC:  r_state <= S_AUIPC;
                            default:     r_state <= S_TRAP;
                        endcase
                    end
                    S_MEMADR:   r_state <= (opcode == c_OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                    S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
                    S_MEMWB:    r_state <= S_FETCH;
                    S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
                    S_EXECR,
                    S_EXECI:    r_state <= S_ALUWB;
                    S_ALUWB:    r_state <= S_FETCH;
                    S_BRANCH:   r_state <= S_FETCH;
                    S_JAL,
                    S_JALR:     r_state <= S_LINK;
                    S_LINK:     r_state <= S_ALUWB;
                    S_LUI,
                    S_AUIPC:    r_state <= S_ALUWB;
                    S_TRAP:     r_state <= S_TRAP;
                    default:    r_state <= S_TRAP;
                endcase
            end
        end
    end

    // Outputs decode from the state register. FETCH, MEMWRITE and BRANCH also
    // use mem_ready / branch_taken in the same cycle. Because of that, these
    // outputs cannot come from an extra register stage. Gating with r_run
    // forces them low as soon as resetn falls, including in the middle of a
    // memory wait.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_write  = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        retire     = 1'b0;
        trap       = 1'b0;
        if (r_run) begin
            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        // PC + 4 straight from the ALU into the PC
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        alu_src_b  = 2'b10;
                        result_src = 2'b10;
                    end
                end
                S_DECODE: begin
                    // oldPC + imm: branch/JAL target lands in ALU-out
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    result_src = 2'b01;
                    retire     = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                    retire  = mem_ready;
                end
                S_EXECR: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b10;
                end
                S_EXECI: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_op    = 2'b10;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b01;
                    pc_write  = branch_taken;
                    retire    = 1'b1;
                end
                S_JAL: begin
                    pc_write = 1'b1;
                end
                S_JALR: begin
                    alu_src_a  = 2'b10;
                    alu_src_b  = 2'b01;
                    result_src = 2'b10;
                    pc_write   = 1'b1;
                end
                S_LINK: begin
                    // oldPC + 4 is the link value written back in ALUWB
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                end
                S_LUI: begin
                    alu_src_a = 2'b11;
                    alu_src_b = 2'b01;
                end
                S_AUIPC: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                S_TRAP: begin
                    trap = 1'b1;
                end
                default: begin
                    trap = 1'b1;
                end
            endcase
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire
